msi_axil_doorbell: RTL and testbench

AXI4-Lite slave register block for the MSI generator: the responder end of the S00_AXI AXI4-Lite control port. It holds four 32-bit software registers and turns doorbell writes into MSI vector requests toward the PCIe MSI interface. Requests are issued through a request/acknowledge handshake and arbitrated lowest-vector-first. It sits between the AXI4-Lite interconnect and the PCIe core's MSI request port.

---
 rtl/msi_axil_doorbell_pkg.sv | 18 +
 rtl/msi_axil_doorbell_arbiter.sv | 78 +++++++
 rtl/msi_axil_doorbell.sv | 154 +++++++++++++++
 tb/tb_msi_axil_doorbell.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msi_axil_doorbell_pkg.sv
// Shared definitions for the MSI doorbell register block.
package msi_axil_doorbell_pkg;

   // Register select values, i.e. byte offset / 4
   localparam logic [1:0] REG_CTRL     = 2'd0;
   localparam logic [1:0] REG_SCRATCH  = 2'd1;
   localparam logic [1:0] REG_DOORBELL = 2'd2;
   localparam logic [1:0] REG_SCRATCH2 = 2'd3;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_GAP  = 2'd2
   } issue_state_e;

endpackage

// File: rtl/msi_axil_doorbell_arbiter.sv
// Pending-vector store and MSI issuer; lowest pending vector goes first.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | no request out; latch lowest pending vector when any is set
// ST_REQ  | msi_req high, vector held; wait for msi_ack
// ST_GAP  | one dead cycle with msi_req low before the next arbitration
module msi_pending_arbiter
   import msi_axil_doorbell_pkg::*;
#(
   parameter int MSI_VECTORS = 32
) (
   input  logic       clk_sys,
   input  logic       rst_b,
   input  logic       set_valid_i,
   input  logic [4:0] set_idx_i,
   input  logic       msi_ack_i,
   output logic       msi_req_o,
   output logic [4:0] msi_vector_o
);

   localparam int IDX_W = (MSI_VECTORS > 1) ? $clog2(MSI_VECTORS) : 1;

   issue_state_e           state_q, state_d;
   logic [MSI_VECTORS-1:0] pending_q, pending_d;
   logic [4:0]             vec_q, vec_d;
   logic [4:0]             low_idx;

   // Priority encoder: scan downward so the lowest set bit is the last to win
   always_comb begin
      low_idx = '0;
      for (int i = MSI_VECTORS - 1; i >= 0; i--) begin
         if (pending_q[i]) low_idx = 5'(i);
      end
   end

   // Next state, pending update and request output; a same-cycle set beats the clear
   always_comb begin
      state_d   = state_q;
      vec_d     = vec_q;
      pending_d = pending_q;
      msi_req_o = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (|pending_q) begin
               state_d = ST_REQ;
               vec_d   = low_idx;
            end
         end
         ST_REQ: begin
            msi_req_o = 1'b1;
            if (msi_ack_i) begin
               pending_d[vec_q[IDX_W-1:0]] = 1'b0;
               state_d                     = ST_GAP;
            end
         end
         ST_GAP:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (set_valid_i) pending_d[set_idx_i[IDX_W-1:0]] = 1'b1;
   end

   // State, latched vector and pending bits
   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         state_q   <= ST_IDLE;
         vec_q     <= '0;
         pending_q <= '0;
      end else begin
         state_q   <= state_d;
         vec_q     <= vec_d;
         pending_q <= pending_d;
      end
   end

   assign msi_vector_o = vec_q;

endmodule

// File: rtl/msi_axil_doorbell.sv
// AXI4-Lite slave with four R/W registers; doorbell writes raise MSI vectors.
module msi_axil_doorbell
   import msi_axil_doorbell_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4,
   parameter int MSI_VECTORS        = 32
) (
   input  logic                            ACLK,
   input  logic                            ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic                            msi_req,
   output logic [4:0]                      msi_vector,
   input  logic                            msi_ack
);

   localparam int SW = C_S_AXI_DATA_WIDTH / 8;

   logic                          rst_done_q;
   logic                          aw_full_q;
   logic                          w_full_q;
   logic [1:0]                    aw_sel_q;
   logic [C_S_AXI_DATA_WIDTH-1:0] w_data_q;
   logic [SW-1:0]                 w_strb_q;
   logic                          bvalid_q;
   logic                          rvalid_q;
   logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
   logic [C_S_AXI_DATA_WIDTH-1:0] regs_q [4];

   logic                          aw_hs;
   logic                          w_hs;
   logic                          ar_hs;
   logic                          do_write;
   logic [1:0]                    wr_sel;
   logic [C_S_AXI_DATA_WIDTH-1:0] wr_data;
   logic [SW-1:0]                 wr_strb;
   logic                          db_set;
   logic [4:0]                    db_idx;
   logic                          unused_ok;

   // READYs stay low through reset and rise on the first edge after release
   assign S_AXI_AWREADY = rst_done_q & ~aw_full_q & ~bvalid_q;
   assign S_AXI_WREADY  = rst_done_q & ~w_full_q & ~bvalid_q;
   assign S_AXI_ARREADY = rst_done_q & ~rvalid_q;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BRESP   = RESP_OKAY;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = RESP_OKAY;

   assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
   assign w_hs  = S_AXI_WVALID & S_AXI_WREADY;
   assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

   // A held slot takes precedence; otherwise the live bus value is used
   assign wr_sel   = aw_full_q ? aw_sel_q : S_AXI_AWADDR[3:2];
   assign wr_data  = w_full_q ? w_data_q : S_AXI_WDATA;
   assign wr_strb  = w_full_q ? w_strb_q : S_AXI_WSTRB;
   assign do_write = (aw_full_q | aw_hs) & (w_full_q | w_hs);

   // msi_en is the pre-write CTRL value; CTRL and DOORBELL cannot be written together
   assign db_set = do_write & (wr_sel == REG_DOORBELL) & wr_strb[0] & regs_q[REG_CTRL][0];
   assign db_idx = wr_data[4:0] & 5'(MSI_VECTORS - 1);

   assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   // Write address/data slots and write response
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         rst_done_q <= 1'b0;
         aw_full_q  <= 1'b0;
         w_full_q   <= 1'b0;
         aw_sel_q   <= '0;
         w_data_q   <= '0;
         w_strb_q   <= '0;
         bvalid_q   <= 1'b0;
      end else begin
         rst_done_q <= 1'b1;
         if (do_write) begin
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            bvalid_q  <= 1'b1;
         end else begin
            if (aw_hs) begin
               aw_full_q <= 1'b1;
               aw_sel_q  <= S_AXI_AWADDR[3:2];
            end
            if (w_hs) begin
               w_full_q <= 1'b1;
               w_data_q <= S_AXI_WDATA;
               w_strb_q <= S_AXI_WSTRB;
            end
         end
         if (bvalid_q && S_AXI_BREADY) bvalid_q <= 1'b0;
      end
   end

   // Register file with byte-lane write enables
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         for (int r = 0; r < 4; r++) regs_q[r] <= '0;
      end else if (do_write) begin
         for (int k = 0; k < SW; k++) begin
            if (wr_strb[k]) regs_q[wr_sel][8*k +: 8] <= wr_data[8*k +: 8];
         end
      end
   end

   // Read channel; data is sampled before any same-edge write lands
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= regs_q[S_AXI_ARADDR[3:2]];
         end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_q <= 1'b0;
         end
      end
   end

   msi_pending_arbiter #(
      .MSI_VECTORS (MSI_VECTORS)
   ) u_arb (
      .clk_sys      (ACLK),
      .rst_b        (ARESETN),
      .set_valid_i  (db_set),
      .set_idx_i    (db_idx),
      .msi_ack_i    (msi_ack),
      .msi_req_o    (msi_req),
      .msi_vector_o (msi_vector)
   );

endmodule

// File: tb/tb_msi_axil_doorbell.sv
// Directed bench for the MSI doorbell register block.
module tb_msi_axil_doorbell;

   logic        ACLK = 1'b0;
   logic        ARESETN;
   logic [3:0]  S_AXI_AWADDR;
   logic [2:0]  S_AXI_AWPROT;
   logic        S_AXI_AWVALID;
   logic        S_AXI_AWREADY;
   logic [31:0] S_AXI_WDATA;
   logic [3:0]  S_AXI_WSTRB;
   logic        S_AXI_WVALID;
   logic        S_AXI_WREADY;
   logic [1:0]  S_AXI_BRESP;
   logic        S_AXI_BVALID;
   logic        S_AXI_BREADY;
   logic [3:0]  S_AXI_ARADDR;
   logic [2:0]  S_AXI_ARPROT;
   logic        S_AXI_ARVALID;
   logic        S_AXI_ARREADY;
   logic [31:0] S_AXI_RDATA;
   logic [1:0]  S_AXI_RRESP;
   logic        S_AXI_RVALID;
   logic        S_AXI_RREADY;
   logic        msi_req;
   logic [4:0]  msi_vector;
   logic        msi_ack;

   int errors = 0;
   int checks = 0;

   localparam logic [3:0] A_CTRL = 4'h0;
   localparam logic [3:0] A_SCR  = 4'h4;
   localparam logic [3:0] A_DB   = 4'h8;
   localparam logic [3:0] A_SCR2 = 4'hC;

   always #5 ACLK = ~ACLK;

   msi_axil_doorbell dut (
      .ACLK          (ACLK),
      .ARESETN       (ARESETN),
      .S_AXI_AWADDR  (S_AXI_AWADDR),
      .S_AXI_AWPROT  (S_AXI_AWPROT),
      .S_AXI_AWVALID (S_AXI_AWVALID),
      .S_AXI_AWREADY (S_AXI_AWREADY),
      .S_AXI_WDATA   (S_AXI_WDATA),
      .S_AXI_WSTRB   (S_AXI_WSTRB),
      .S_AXI_WVALID  (S_AXI_WVALID),
      .S_AXI_WREADY  (S_AXI_WREADY),
      .S_AXI_BRESP   (S_AXI_BRESP),
      .S_AXI_BVALID  (S_AXI_BVALID),
      .S_AXI_BREADY  (S_AXI_BREADY),
      .S_AXI_ARADDR  (S_AXI_ARADDR),
      .S_AXI_ARPROT  (S_AXI_ARPROT),
      .S_AXI_ARVALID (S_AXI_ARVALID),
      .S_AXI_ARREADY (S_AXI_ARREADY),
      .S_AXI_RDATA   (S_AXI_RDATA),
      .S_AXI_RRESP   (S_AXI_RRESP),
      .S_AXI_RVALID  (S_AXI_RVALID),
      .S_AXI_RREADY  (S_AXI_RREADY),
      .msi_req       (msi_req),
      .msi_vector    (msi_vector),
      .msi_ack       (msi_ack)
   );

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
      int n;
      S_AXI_BREADY  = 1'b1;
      S_AXI_AWADDR  = addr;
      S_AXI_WDATA   = data;
      S_AXI_WSTRB   = strb;
      S_AXI_AWVALID = 1'b1;
      S_AXI_WVALID  = 1'b1;
      n = 0;
      while (!(S_AXI_AWREADY && S_AXI_WREADY) && n < 50) begin tick(); n++; end
      checks++;
      if (n >= 50) begin errors++; $display("FAIL wr_ready_timeout addr=%h", addr); end
      tick();
      S_AXI_AWVALID = 1'b0;
      S_AXI_WVALID  = 1'b0;
      n = 0;
      while (!S_AXI_BVALID && n < 50) begin tick(); n++; end
      checks++;
      if (n >= 50) begin errors++; $display("FAIL bvalid_timeout addr=%h", addr); end
      resp = S_AXI_BRESP;
      tick();
   endtask

   task automatic axi_read(input logic [3:0] addr, output logic [31:0] data,
                           output logic [1:0] resp);
      int n;
      S_AXI_RREADY  = 1'b1;
      S_AXI_ARADDR  = addr;
      S_AXI_ARVALID = 1'b1;
      n = 0;
      while (!S_AXI_ARREADY && n < 50) begin tick(); n++; end
      checks++;
      if (n >= 50) begin errors++; $display("FAIL arready_timeout addr=%h", addr); end
      tick();
      S_AXI_ARVALID = 1'b0;
      n = 0;
      while (!S_AXI_RVALID && n < 50) begin tick(); n++; end
      checks++;
      if (n >= 50) begin errors++; $display("FAIL rvalid_timeout addr=%h", addr); end
      data = S_AXI_RDATA;
      resp = S_AXI_RRESP;
      tick();
   endtask

   // Wait for a request, check its vector, ack two cycles later, check GAP
   task automatic serve_vec(input logic [4:0] exp_vec);
      int n;
      n = 0;
      while (!msi_req && n < 30) begin tick(); n++; end
      checks++;
      if (!msi_req) begin errors++; $display("FAIL req_timeout exp_vec=%0d", exp_vec); end
      checks++;
      if (msi_vector !== exp_vec) begin
         errors++; $display("FAIL req_vector got=%0d exp=%0d", msi_vector, exp_vec);
      end
      repeat (2) tick();
      checks++;
      if (msi_req !== 1'b1 || msi_vector !== exp_vec) begin
         errors++;
         $display("FAIL req_hold req=%b vec=%0d exp_vec=%0d", msi_req, msi_vector, exp_vec);
      end
      msi_ack = 1'b1;
      tick();
      msi_ack = 1'b0;
      checks++;
      if (msi_req !== 1'b0) begin errors++; $display("FAIL gap_req got=%b exp=0", msi_req); end
   endtask

   task automatic test_reset();
      ARESETN = 1'b0;
      repeat (3) tick();
      checks++;
      if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID, msi_req} !== 6'b0
          || msi_vector !== 5'd0 || S_AXI_RDATA !== 32'd0 || S_AXI_BRESP !== 2'b00
          || S_AXI_RRESP !== 2'b00) begin
         errors++;
         $display("FAIL reset_outputs awr=%b wr=%b arr=%b bv=%b rv=%b req=%b vec=%0d rdata=%h exp all 0",
                  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID,
                  msi_req, msi_vector, S_AXI_RDATA);
      end
      ARESETN = 1'b1;
      #1;
      checks++;
      if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b000) begin
         errors++;
         $display("FAIL ready_before_edge got=%b exp=000", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
      end
      tick();
      checks++;
      if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b111) begin
         errors++;
         $display("FAIL ready_after_edge got=%b exp=111", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
      end
   endtask

   task automatic test_basic_rw();
      logic [3:0]  addrs [4];
      logic [31:0] vals  [4];
      logic [31:0] rd;
      logic [1:0]  rsp;
      addrs[0] = A_CTRL; addrs[1] = A_SCR; addrs[2] = A_DB; addrs[3] = A_SCR2;
      vals[0] = 32'h0101FFFF; vals[1] = 32'habcd0001;
      vals[2] = 32'hdead0011; vals[3] = 32'hbeef0011;
      for (int i = 0; i < 4; i++) begin
         axi_write(addrs[i], vals[i], 4'hF, rsp);
         checks++;
         if (rsp !== 2'b00) begin errors++; $display("FAIL bresp[%0d] got=%b exp=00", i, rsp); end
      end
      for (int i = 0; i < 4; i++) begin
         axi_read(addrs[i], rd, rsp);
         checks++;
         if (rd !== vals[i]) begin errors++; $display("FAIL readback[%0d] got=%h exp=%h", i, rd, vals[i]); end
         checks++;
         if (rsp !== 2'b00) begin errors++; $display("FAIL rresp[%0d] got=%b exp=00", i, rsp); end
      end
      // CTRL bit0 was set, so the 0x11 doorbell raised vector 17
      serve_vec(5'd17);
   endtask

   task automatic test_split_write();
      logic [31:0] rd;
      logic [1:0]  rsp;
      int          bcount;
      // W three cycles ahead of AW
      S_AXI_BREADY = 1'b0;
      S_AXI_WDATA  = 32'h11112222;
      S_AXI_WSTRB  = 4'hF;
      S_AXI_WVALID = 1'b1;
      tick();
      S_AXI_WVALID = 1'b0;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (S_AXI_WREADY !== 1'b0 || S_AXI_AWREADY !== 1'b1 || S_AXI_BVALID !== 1'b0) begin
            errors++;
            $display("FAIL w_held[%0d] wr=%b awr=%b bv=%b exp 0/1/0", i, S_AXI_WREADY, S_AXI_AWREADY, S_AXI_BVALID);
         end
         tick();
      end
      S_AXI_AWADDR  = A_SCR2;
      S_AXI_AWVALID = 1'b1;
      tick();
      S_AXI_AWVALID = 1'b0;
      bcount = 0;
      for (int i = 0; i < 5; i++) begin
         if (S_AXI_BVALID === 1'b1) bcount++;
         checks++;
         if (S_AXI_AWREADY !== 1'b0 || S_AXI_WREADY !== 1'b0) begin
            errors++;
            $display("FAIL ready_during_b[%0d] awr=%b wr=%b exp 0/0", i, S_AXI_AWREADY, S_AXI_WREADY);
         end
         tick();
      end
      checks++;
      if (bcount !== 5) begin errors++; $display("FAIL bvalid_hold got=%0d cycles exp=5", bcount); end
      S_AXI_BREADY = 1'b1;
      tick();
      checks++;
      if (S_AXI_BVALID !== 1'b0 || S_AXI_AWREADY !== 1'b1 || S_AXI_WREADY !== 1'b1) begin
         errors++;
         $display("FAIL b_release bv=%b awr=%b wr=%b exp 0/1/1", S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY);
      end
      axi_read(A_SCR2, rd, rsp);
      checks++;
      if (rd !== 32'h11112222) begin errors++; $display("FAIL w_first_data got=%h exp=11112222", rd); end

      // AW three cycles ahead of W
      S_AXI_AWADDR  = A_SCR;
      S_AXI_AWVALID = 1'b1;
      tick();
      S_AXI_AWVALID = 1'b0;
      repeat (2) tick();
      checks++;
      if (S_AXI_AWREADY !== 1'b0 || S_AXI_WREADY !== 1'b1 || S_AXI_BVALID !== 1'b0) begin
         errors++;
         $display("FAIL aw_held awr=%b wr=%b bv=%b exp 0/1/0", S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID);
      end
      S_AXI_WDATA  = 32'h33334444;
      S_AXI_WVALID = 1'b1;
      tick();
      S_AXI_WVALID = 1'b0;
      checks++;
      if (S_AXI_BVALID !== 1'b1) begin errors++; $display("FAIL aw_first_bvalid got=%b exp=1", S_AXI_BVALID); end
      tick();
      axi_read(A_SCR, rd, rsp);
      checks++;
      if (rd !== 32'h33334444) begin errors++; $display("FAIL aw_first_data got=%h exp=33334444", rd); end
   endtask

   task automatic test_strobe();
      logic [31:0] rd;
      logic [1:0]  rsp;
      axi_write(A_SCR, 32'hFFFFFFFF, 4'hF, rsp);
      axi_write(A_SCR, 32'h12345678, 4'b0101, rsp);
      axi_read(A_SCR, rd, rsp);
      checks++;
      if (rd !== 32'hFF34FF78) begin errors++; $display("FAIL strobe_merge got=%h exp=FF34FF78", rd); end
   endtask

   task automatic test_doorbell_order();
      logic [1:0] rsp;
      int         hits;
      axi_write(A_CTRL, 32'h1, 4'hF, rsp);
      // Vector 31 occupies the issuer while 9 and 3 both become pending
      axi_write(A_DB, 32'h1F, 4'hF, rsp);
      axi_write(A_DB, 32'h09, 4'hF, rsp);
      axi_write(A_DB, 32'h03, 4'hF, rsp);
      serve_vec(5'd31);
      serve_vec(5'd3);
      tick();
      checks++;
      if (msi_req !== 1'b0) begin errors++; $display("FAIL idle_after_gap got=%b exp=0", msi_req); end
      tick();
      checks++;
      if (msi_req !== 1'b1 || msi_vector !== 5'd9) begin
         errors++; $display("FAIL next_req_spacing req=%b vec=%0d exp 1/9", msi_req, msi_vector);
      end
      serve_vec(5'd9);
      hits = 0;
      for (int i = 0; i < 10; i++) begin tick(); if (msi_req === 1'b1) hits++; end
      checks++;
      if (hits !== 0) begin errors++; $display("FAIL reissue got=%0d req cycles exp=0", hits); end
   endtask

   task automatic test_doorbell_disabled();
      logic [31:0] rd;
      logic [1:0]  rsp;
      int          hits;
      axi_write(A_CTRL, 32'h0, 4'hF, rsp);
      axi_write(A_DB, 32'h05, 4'hF, rsp);
      hits = 0;
      for (int i = 0; i < 20; i++) begin if (msi_req === 1'b1) hits++; tick(); end
      checks++;
      if (hits !== 0) begin errors++; $display("FAIL disabled_req got=%0d req cycles exp=0", hits); end
      axi_read(A_DB, rd, rsp);
      checks++;
      if (rd !== 32'h00000005) begin errors++; $display("FAIL disabled_db_reg got=%h exp=00000005", rd); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd;
      logic [1:0]  rsp;
      logic [3:0]  addrs [4];
      int          n;
      addrs[0] = A_CTRL; addrs[1] = A_SCR; addrs[2] = A_DB; addrs[3] = A_SCR2;
      axi_write(A_CTRL, 32'h1, 4'hF, rsp);
      axi_write(A_DB, 32'h02, 4'hF, rsp);
      n = 0;
      while (!msi_req && n < 20) begin tick(); n++; end
      S_AXI_BREADY  = 1'b0;
      S_AXI_AWADDR  = A_SCR;
      S_AXI_WDATA   = 32'hAAAA5555;
      S_AXI_WSTRB   = 4'hF;
      S_AXI_AWVALID = 1'b1;
      S_AXI_WVALID  = 1'b1;
      tick();
      S_AXI_AWVALID = 1'b0;
      S_AXI_WVALID  = 1'b0;
      checks++;
      if (msi_req !== 1'b1 || S_AXI_BVALID !== 1'b1 || msi_vector !== 5'd2) begin
         errors++;
         $display("FAIL pre_reset req=%b bv=%b vec=%0d exp 1/1/2", msi_req, S_AXI_BVALID, msi_vector);
      end
      #2;
      ARESETN = 1'b0;
      #1;
      checks++;
      if (msi_req !== 1'b0 || S_AXI_BVALID !== 1'b0 || msi_vector !== 5'd0) begin
         errors++;
         $display("FAIL async_reset req=%b bv=%b vec=%0d exp 0/0/0", msi_req, S_AXI_BVALID, msi_vector);
      end
      repeat (2) @(posedge ACLK);
      #1;
      ARESETN      = 1'b1;
      S_AXI_BREADY = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         axi_read(addrs[i], rd, rsp);
         checks++;
         if (rd !== 32'd0) begin errors++; $display("FAIL post_reset_reg[%0d] got=%h exp=0", i, rd); end
      end
      checks++;
      if (msi_req !== 1'b0) begin errors++; $display("FAIL post_reset_req got=%b exp=0", msi_req); end
   endtask

   initial begin
      ARESETN       = 1'b0;
      S_AXI_AWADDR  = '0;
      S_AXI_AWPROT  = '0;
      S_AXI_AWVALID = 1'b0;
      S_AXI_WDATA   = '0;
      S_AXI_WSTRB   = '0;
      S_AXI_WVALID  = 1'b0;
      S_AXI_BREADY  = 1'b1;
      S_AXI_ARADDR  = '0;
      S_AXI_ARPROT  = '0;
      S_AXI_ARVALID = 1'b0;
      S_AXI_RREADY  = 1'b1;
      msi_ack       = 1'b0;
      test_reset();
      test_basic_rw();
      test_split_write();
      test_strobe();
      test_doorbell_order();
      test_doorbell_disabled();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
